// File: rtl/branch_predictor_pkg.sv
// Shared definitions for the direct-mapped BTB/BHT branch predictor.
package branch_predictor_pkg;

    localparam int ENTRIES_DEF = 64;

    // 2-bit saturating counter encoding; bit 1 is the taken prediction
    localparam logic [1:0] SNT = 2'b00;
    localparam logic [1:0] WNT = 2'b01;
    localparam logic [1:0] WT  = 2'b10;
    localparam logic [1:0] ST  = 2'b11;

    // index width: log2 of the table depth
    function automatic int idx_w(input int entries);
        return $clog2(entries);
    endfunction

    // tag width: everything above the index and the byte offset
    function automatic int tag_w(input int entries);
        return 30 - $clog2(entries);
    endfunction

endpackage

// File: rtl/branch_predictor_sat_counter2.sv
// 2-bit saturating up/down counter next-state logic.
module sat_counter2
    import branch_predictor_pkg::*;
(
    input  logic [1:0] state,
    input  logic       taken,
    output logic [1:0] next_state
);

    // count toward ST on taken, toward SNT on not-taken, holding at the ends
    always_comb begin
        next_state = state;
        if (taken) begin
            if (state != ST) next_state = state + 2'd1;
        end else begin
            if (state != SNT) next_state = state - 2'd1;
        end
    end

endmodule

// File: rtl/branch_predictor.sv
// Direct-mapped BTB with per-entry 2-bit history; combinational lookup at IF,
// training and statistics at EX.
module branch_predictor
    import branch_predictor_pkg::*;
#(
    parameter int ENTRIES = ENTRIES_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] PC_IF,
    output logic [31:0] PC_pred_IF,
    output logic        PC_pred_en_IF,
    input  logic        update_en,
    input  logic        is_br_EX,
    input  logic [31:0] PC_EX_br,
    input  logic        br_taken_EX,
    input  logic [31:0] br_target_EX,
    input  logic        PC_pred_en_EX,
    output logic [31:0] br_count,
    output logic [31:0] mispred_count
);

    localparam int IW = idx_w(ENTRIES);
    localparam int TW = tag_w(ENTRIES);

    // entry storage kept in flops so the IF lookup is asynchronous
    logic [ENTRIES-1:0]             valid_q, valid_d;
    logic [ENTRIES-1:0][TW-1:0]     tag_q,   tag_d;
    logic [ENTRIES-1:0][31:0]       tgt_q,   tgt_d;
    logic [ENTRIES-1:0][1:0]        st_q,    st_d;
    logic [31:0]                    br_count_q, br_count_d;
    logic [31:0]                    mispred_count_q, mispred_count_d;

    logic [IW-1:0] if_idx, ex_idx;
    logic [TW-1:0] if_tag, ex_tag;
    logic          do_upd, ex_hit;
    logic [1:0]    sat_next;

    // byte-offset bits never participate in indexing
    logic unused_pc_lsbs;
    assign unused_pc_lsbs = ^{PC_IF[1:0], PC_EX_br[1:0]};

    assign if_idx = PC_IF[IW+1:2];
    assign if_tag = PC_IF[31:IW+2];
    assign ex_idx = PC_EX_br[IW+1:2];
    assign ex_tag = PC_EX_br[31:IW+2];
    assign do_upd = update_en & is_br_EX;
    assign ex_hit = valid_q[ex_idx] && (tag_q[ex_idx] == ex_tag);

    sat_counter2 u_sat (
        .state      (st_q[ex_idx]),
        .taken      (br_taken_EX),
        .next_state (sat_next)
    );

    // lookup reads only registered state, so same-cycle updates appear next cycle
    always_comb begin
        PC_pred_en_IF = valid_q[if_idx] && (tag_q[if_idx] == if_tag) && st_q[if_idx][1];
        PC_pred_IF    = PC_pred_en_IF ? tgt_q[if_idx] : 32'h0;
    end

    // train the indexed entry and bump the statistics counters
    always_comb begin
        valid_d         = valid_q;
        tag_d           = tag_q;
        tgt_d           = tgt_q;
        st_d            = st_q;
        br_count_d      = br_count_q;
        mispred_count_d = mispred_count_q;
        if (do_upd) begin
            br_count_d = br_count_q + 32'd1;
            if (PC_pred_en_EX != br_taken_EX)
                mispred_count_d = mispred_count_q + 32'd1;
            if (ex_hit) begin
                st_d[ex_idx] = sat_next;
                if (br_taken_EX) tgt_d[ex_idx] = br_target_EX;
            end else if (br_taken_EX) begin
                // a taken miss evicts whatever occupied the slot
                valid_d[ex_idx] = 1'b1;
                tag_d[ex_idx]   = ex_tag;
                tgt_d[ex_idx]   = br_target_EX;
                st_d[ex_idx]    = WT;
            end
        end
    end

    // valid bits, history and counters; reset wins over any update
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q         <= '0;
            st_q            <= {ENTRIES{SNT}};
            br_count_q      <= '0;
            mispred_count_q <= '0;
        end else begin
            valid_q         <= valid_d;
            st_q            <= st_d;
            br_count_q      <= br_count_d;
            mispred_count_q <= mispred_count_d;
        end
    end

    // tags and targets carry no reset; they are meaningless while invalid
    always_ff @(posedge clk) begin
        if (!rst) begin
            tag_q <= tag_d;
            tgt_q <= tgt_d;
        end
    end

    assign br_count      = br_count_q;
    assign mispred_count = mispred_count_q;

endmodule

// File: tb/tb_branch_predictor.sv
// Table-driven check of the branch predictor with a scoreboard queue.
module tb_branch_predictor;

    logic        clk;
    logic        rst;
    logic [31:0] PC_IF;
    logic [31:0] PC_pred_IF;
    logic        PC_pred_en_IF;
    logic        update_en;
    logic        is_br_EX;
    logic [31:0] PC_EX_br;
    logic        br_taken_EX;
    logic [31:0] br_target_EX;
    logic        PC_pred_en_EX;
    logic [31:0] br_count;
    logic [31:0] mispred_count;

    branch_predictor #(.ENTRIES(64)) dut (
        .clk           (clk),
        .rst           (rst),
        .PC_IF         (PC_IF),
        .PC_pred_IF    (PC_pred_IF),
        .PC_pred_en_IF (PC_pred_en_IF),
        .update_en     (update_en),
        .is_br_EX      (is_br_EX),
        .PC_EX_br      (PC_EX_br),
        .br_taken_EX   (br_taken_EX),
        .br_target_EX  (br_target_EX),
        .PC_pred_en_EX (PC_pred_en_EX),
        .br_count      (br_count),
        .mispred_count (mispred_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        upd_en;
        logic        is_br;
        logic [31:0] pc_ex;
        logic        taken;
        logic [31:0] tgt;
        logic        pen;
        logic [31:0] pc_if;
        logic        exp_en;
        logic [31:0] exp_pc;
        logic [31:0] exp_br;
        logic [31:0] exp_mis;
    } vec_t;

    typedef struct {
        int          row;
        logic        en;
        logic [31:0] pc;
        logic [31:0] br;
        logic [31:0] mis;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    function automatic vec_t mk(logic r, logic ue, logic ib, logic [31:0] pex, logic tk,
                                logic [31:0] tg, logic pe, logic [31:0] pif, logic een,
                                logic [31:0] epc, logic [31:0] ebr, logic [31:0] emis);
        vec_t v;
        v.rst = r; v.upd_en = ue; v.is_br = ib; v.pc_ex = pex; v.taken = tk; v.tgt = tg;
        v.pen = pe; v.pc_if = pif; v.exp_en = een; v.exp_pc = epc; v.exp_br = ebr;
        v.exp_mis = emis;
        return v;
    endfunction

    task automatic chk(input string name, input int row, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s row %0d: got %h expected %h", name, row, act, exp);
        end
    endtask

    // drive one row, push its expectation, sample before the edge, then clock
    task automatic apply(input int row, input vec_t v);
        exp_t e, g;
        rst = v.rst; update_en = v.upd_en; is_br_EX = v.is_br; PC_EX_br = v.pc_ex;
        br_taken_EX = v.taken; br_target_EX = v.tgt; PC_pred_en_EX = v.pen; PC_IF = v.pc_if;
        e.row = row; e.en = v.exp_en; e.pc = v.exp_pc; e.br = v.exp_br; e.mis = v.exp_mis;
        sb.push_back(e);
        @(negedge clk);
        g = sb.pop_front();
        chk("pred_en", g.row, {31'd0, PC_pred_en_IF}, {31'd0, g.en});
        chk("pred_pc", g.row, PC_pred_IF, g.pc);
        chk("br_count", g.row, br_count, g.br);
        chk("mispred_count", g.row, mispred_count, g.mis);
        @(posedge clk);
        #1;
    endtask

    initial begin
        // expected outputs are those seen during the row, before its clock edge
        //            rst ue ib pc_ex         tk tgt           pe pc_if         en pc            br  mis
        vecs.push_back(mk(0, 0, 0, 32'h0,       0, 32'h0,      0, 32'h40,  0, 32'h0,   0,  0)); // post-reset
        vecs.push_back(mk(0, 1, 1, 32'h40,      1, 32'h80,     0, 32'h40,  0, 32'h0,   0,  0)); // alloc, same cycle
        vecs.push_back(mk(0, 0, 0, 32'h0,       0, 32'h0,      0, 32'h40,  1, 32'h80,  1,  1)); // hit WT
        vecs.push_back(mk(0, 1, 1, 32'h40,      0, 32'h0,      1, 32'h40,  1, 32'h80,  1,  1)); // NT -> WNT
        vecs.push_back(mk(0, 0, 0, 32'h0,       0, 32'h0,      0, 32'h40,  0, 32'h0,   2,  2));
        vecs.push_back(mk(0, 1, 1, 32'h40,      1, 32'h84,     0, 32'h40,  0, 32'h0,   2,  2)); // T -> WT
        vecs.push_back(mk(0, 0, 0, 32'h0,       0, 32'h0,      0, 32'h40,  1, 32'h84,  3,  3));
        vecs.push_back(mk(0, 1, 1, 32'h40,      1, 32'h88,     1, 32'h40,  1, 32'h84,  3,  3)); // T -> ST
        vecs.push_back(mk(0, 0, 0, 32'h0,       0, 32'h0,      0, 32'h40,  1, 32'h88,  4,  3));
        vecs.push_back(mk(0, 1, 1, 32'h40,      1, 32'h88,     1, 32'h40,  1, 32'h88,  4,  3)); // ST sat
        vecs.push_back(mk(0, 1, 1, 32'h40,      0, 32'h0,      1, 32'h40,  1, 32'h88,  5,  3)); // ST -> WT
        vecs.push_back(mk(0, 0, 0, 32'h0,       0, 32'h0,      0, 32'h40,  1, 32'h88,  6,  4));
        vecs.push_back(mk(0, 1, 1, 32'h140,     1, 32'h200,    0, 32'h140, 0, 32'h0,   6,  4)); // alias evict
        vecs.push_back(mk(0, 0, 0, 32'h0,       0, 32'h0,      0, 32'h40,  0, 32'h0,   7,  5));
        vecs.push_back(mk(0, 0, 0, 32'h0,       0, 32'h0,      0, 32'h140, 1, 32'h200, 7,  5));
        vecs.push_back(mk(0, 1, 1, 32'h140,     0, 32'h0,      1, 32'h140, 1, 32'h200, 7,  5)); // -> WNT
        vecs.push_back(mk(0, 1, 1, 32'h140,     0, 32'h0,      0, 32'h140, 0, 32'h0,   8,  6)); // -> SNT
        vecs.push_back(mk(0, 1, 1, 32'h140,     0, 32'h0,      0, 32'h140, 0, 32'h0,   9,  6)); // SNT sat
        vecs.push_back(mk(0, 1, 1, 32'h140,     1, 32'h204,    0, 32'h140, 0, 32'h0,  10,  6)); // -> WNT
        vecs.push_back(mk(0, 0, 0, 32'h0,       0, 32'h0,      0, 32'h140, 0, 32'h0,  11,  7));
        vecs.push_back(mk(0, 1, 1, 32'h140,     1, 32'h208,    0, 32'h140, 0, 32'h0,  11,  7)); // -> WT
        vecs.push_back(mk(0, 0, 0, 32'h0,       0, 32'h0,      0, 32'h140, 1, 32'h208,12,  8));
        vecs.push_back(mk(0, 0, 1, 32'h40,      1, 32'h300,    0, 32'h140, 1, 32'h208,12,  8)); // gated
        vecs.push_back(mk(0, 0, 0, 32'h0,       0, 32'h0,      0, 32'h40,  0, 32'h0,  12,  8));
        vecs.push_back(mk(0, 1, 1, 32'h44,      0, 32'h0,      0, 32'h44,  0, 32'h0,  12,  8)); // NT miss
        vecs.push_back(mk(0, 0, 0, 32'h0,       0, 32'h0,      0, 32'h44,  0, 32'h0,  13,  8));
        vecs.push_back(mk(0, 1, 0, 32'h44,      1, 32'h400,    1, 32'h44,  0, 32'h0,  13,  8)); // not a branch
        vecs.push_back(mk(0, 0, 0, 32'h0,       0, 32'h0,      0, 32'h44,  0, 32'h0,  13,  8));
        vecs.push_back(mk(1, 1, 1, 32'h44,      1, 32'h500,    0, 32'h140, 1, 32'h208,13,  8)); // rst + update
        vecs.push_back(mk(0, 0, 0, 32'h0,       0, 32'h0,      0, 32'h140, 0, 32'h0,   0,  0));
        vecs.push_back(mk(0, 0, 0, 32'h0,       0, 32'h0,      0, 32'h44,  0, 32'h0,   0,  0));

        rst = 1'b1; update_en = 1'b0; is_br_EX = 1'b0; PC_EX_br = '0; br_taken_EX = 1'b0;
        br_target_EX = '0; PC_pred_en_EX = 1'b0; PC_IF = 32'h40;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        foreach (vecs[i]) apply(i, vecs[i]);

        // sweep every index right after the second reset: nothing may predict
        for (int k = 0; k < 64; k++) begin
            PC_IF = {$urandom_range(0, 255), 8'h0} | (k << 2);
            #1;
            chk("post_reset_sweep", k, {31'd0, PC_pred_en_IF}, 32'd0);
        end

        if (sb.size() != 0) begin
            n_bad++;
            $display("FAIL scoreboard_drain: got %0d left expected 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/branch_predictor.md
BRANCH_PREDICTOR -- requirements
Module: branch_predictor

Interface
REQ-001 SHALL have parameter ENTRIES, default 64, meaning number of direct-mapped BTB/BHT entries (power of two, 4..256).
REQ-002 SHALL have port clk  input  1  core clock; all state updates on the rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port PC_IF  input  32  address of the instruction being fetched this cycle.
REQ-005 SHALL have port PC_pred_IF  output  32  predicted next-fetch target for PC_IF.
REQ-006 SHALL have port PC_pred_en_IF  output  1  1 = predict taken, so the NPC logic selects PC_pred_IF.
REQ-007 SHALL have port update_en  input  1  EX stage holds a valid, non-bubbled instruction this cycle.
REQ-008 SHALL have port is_br_EX  input  1  EX instruction is a conditional branch.
REQ-009 SHALL have port PC_EX_br  input  32  address of the EX branch (not PC+4).
REQ-010 SHALL have port br_taken_EX  input  1  resolved branch outcome.
REQ-011 SHALL have port br_target_EX  input  32  resolved branch target.
REQ-012 SHALL have port PC_pred_en_EX  input  1  prediction made for this branch at IF, carried down the pipeline.
REQ-013 SHALL have port br_count  output  32  branches retired through EX since reset.
REQ-014 SHALL have port mispred_count  output  32  mispredicted branches since reset.

Function
REQ-015 SHALL split each address into index = PC[IW+1:2] and tag = PC[31:IW+2], where IW = log2(ENTRIES).
REQ-016 Each entry SHALL hold a valid bit, a tag, a 32-bit target and a 2-bit state.
REQ-017 Lookup SHALL be combinational (zero latency): PC_pred_en_IF = valid & tag match & state[1]; PC_pred_IF = entry target.
REQ-018 PC_pred_IF SHALL be 0 whenever PC_pred_en_IF is 0.
REQ-019 State encoding SHALL be: SNT=00, WNT=01, WT=10, ST=11.
REQ-020 On a taken branch, state SHALL saturate up: SNT->WNT->WT->ST->ST.
REQ-021 On a not-taken branch, state SHALL saturate down: ST->WT->WNT->SNT->SNT.
REQ-022 An update SHALL occur only when update_en & is_br_EX; no state changes otherwise.
REQ-023 Update with tag hit SHALL apply REQ-020/021 and, if taken, overwrite the target with br_target_EX.
REQ-024 Update with tag miss and taken SHALL allocate (replacing any occupant): valid=1, tag and target written, state=WT.
REQ-025 Update with tag miss and not taken SHALL leave the entry unchanged.
REQ-026 When a lookup and an update hit the same index in one cycle, the lookup SHALL return pre-update contents; the new value is visible the next cycle.
REQ-027 Every update SHALL increment br_count by 1, mod 2^32.
REQ-028 An update SHALL increment mispred_count by 1, mod 2^32, when PC_pred_en_EX != br_taken_EX.
REQ-029 Both counters SHALL wrap from 0xFFFFFFFF to 0.

Reset
REQ-030 While rst=1 at a clock edge, all valid bits SHALL clear, all states SHALL go to SNT, and br_count and mispred_count SHALL go to 0; targets and tags may retain old values.
REQ-031 rst SHALL take priority over a simultaneous update; no update from that cycle is kept.
REQ-032 In the cycle after reset, PC_pred_en_IF SHALL be 0 for every PC_IF.

Structure
REQ-033 A shared package SHALL hold: ENTRIES default, index/tag width functions, and the 2-bit state encoding constants SNT/WNT/WT/ST.
REQ-034 The saturating-counter next-state logic SHALL be a sub-module sat_counter2 with inputs state and taken and output next state.
REQ-035 Entry storage SHALL be flip-flop arrays; no RAM macro, because lookup must be asynchronous.

Verification
REQ-036 After reset, PC_IF=0x00000040 -> PC_pred_en_IF=0 and PC_pred_IF=0; both counters read 0.
REQ-037 Allocate and hit: update PC_EX_br=0x40, taken=1, target=0x80, PC_pred_en_EX=0; next cycle PC_IF=0x40 -> PC_pred_en_IF=1, PC_pred_IF=0x80; br_count=1, mispred_count=1.
REQ-038 Hysteresis: from WT, apply one not-taken for 0x40 -> state WNT, PC_pred_en_IF=0; then one taken -> WT, PC_pred_en_IF=1.
REQ-039 Aliasing: with ENTRIES=64, 0x40 allocated, then taken update for 0x140 (same index, different tag) -> PC_IF=0x40 predicts 0; PC_IF=0x140 predicts its new target.
REQ-040 Same-cycle read/write: PC_IF=0x40 while an allocating update for 0x40 is applied -> PC_pred_en_IF=0 that cycle and 1 the next.
REQ-041 Gating and reset: update with update_en=0 -> no change and no count; rst asserted together with an update -> all entries invalid and counters 0 after that edge.
